// File: rtl/multi_ch_xfer_sched_if.sv
// ============================================================================
// multi_ch_xfer_sched_if - per-channel read-master request/done bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface multi_ch_xfer_sched_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 64
);
  logic [NUM_CH-1:0]        rd_req;
  logic [NUM_CH-1:0]        rd_done;
  logic [NUM_CH*ADDR_W-1:0] rd_offset;
  logic [NUM_CH*ADDR_W-1:0] rd_xfer_size;

  modport master (
    output rd_req,
    output rd_offset,
    output rd_xfer_size,
    input  rd_done
  );

  modport slave (
    input  rd_req,
    input  rd_offset,
    input  rd_xfer_size,
    output rd_done
  );
endinterface

`default_nettype wire

// File: rtl/multi_ch_xfer_sched.sv
// ============================================================================
// multi_ch_xfer_sched - splits per-channel byte regions into chunked reads
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_ch_xfer_sched #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 64,
  parameter int SIZE_W      = 32,
  parameter int CHUNK_BYTES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_start_i,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_base_i,
  input  logic [NUM_CH*SIZE_W-1:0] cfg_size_i,
  input  logic [NUM_CH*8-1:0]      cfg_pass_i,
  multi_ch_xfer_sched_if.master    rd_if,
  input  logic [NUM_CH-1:0]        buf_space_ok_i,
  input  logic [NUM_CH-1:0]        buf_empty_i,
  input  logic                     end_conv_i,
  output logic                     g_stall_o,
  output logic                     start_conv_o,
  output logic [NUM_CH-1:0]        xfer_clear_o,
  output logic                     busy_o
);

  localparam logic [SIZE_W-1:0] c_CHUNK = SIZE_W'(CHUNK_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  logic [NUM_CH*ADDR_W-1:0] cfg_base_q;
  logic [NUM_CH*SIZE_W-1:0] cfg_size_q;
  logic [NUM_CH*8-1:0]      cfg_pass_q;
  logic                     p_start_q, p_start_d;
  logic                     busy_q, busy_d;
  logic                     pend_q, pend_d;

  logic [NUM_CH-1:0]        w_idle;
  logic [NUM_CH-1:0]        w_req;
  logic [NUM_CH-1:0]        w_clr;
  logic [NUM_CH*ADDR_W-1:0] w_off;
  logic [NUM_CH*ADDR_W-1:0] w_size;
  logic                     w_stall;

  assign w_stall = |(buf_empty_i & ~w_clr & {NUM_CH{busy_q}});

  always_comb begin
    p_start_d = op_start_i & ~busy_q;
    busy_d    = busy_q;
    if (p_start_d) begin
      busy_d = 1'b1;
    end else if (!p_start_q && (&w_idle)) begin
      busy_d = 1'b0;
    end
    // Pending start survives only while stalled; it fires the moment the stall lifts.
    pend_d = end_conv_i ? 1'b0 : ((pend_q | p_start_q) & w_stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_base_q <= '0;
      cfg_size_q <= '0;
      cfg_pass_q <= '0;
      p_start_q  <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      p_start_q <= p_start_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      if (p_start_d) begin
        cfg_base_q <= cfg_base_i;
        cfg_size_q <= cfg_size_i;
        cfg_pass_q <= cfg_pass_i;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t            st_q;
    logic [SIZE_W-1:0] rem_q;
    logic [SIZE_W-1:0] xsize_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        pass_q;
    logic              req_q;
    logic              clr_q;
    logic              abort_q;
    logic [SIZE_W-1:0] w_chunk;
    logic [ADDR_W-1:0] w_cbase;
    logic [SIZE_W-1:0] w_csize;
    logic [7:0]        w_cpass;

    assign w_cbase = cfg_base_q[c*ADDR_W +: ADDR_W];
    assign w_csize = cfg_size_q[c*SIZE_W +: SIZE_W];
    assign w_cpass = cfg_pass_q[c*8 +: 8];
    assign w_chunk = (rem_q > c_CHUNK) ? c_CHUNK : rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q    <= S_IDLE;
        rem_q   <= '0;
        xsize_q <= '0;
        addr_q  <= '0;
        pass_q  <= '0;
        req_q   <= 1'b0;
        clr_q   <= 1'b0;
        abort_q <= 1'b0;
      end else begin
        case (st_q)
          S_IDLE: begin
            abort_q <= 1'b0;
            if (p_start_q) begin
              rem_q  <= w_csize;
              addr_q <= w_cbase;
              pass_q <= (w_cpass == 8'd0) ? 8'd1 : w_cpass;
              st_q   <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (end_conv_i) begin
              st_q <= S_IDLE;
            end else if (rem_q == '0) begin
              if (pass_q <= 8'd1) begin
                st_q  <= S_DONE;
                clr_q <= 1'b1;
              end else begin
                pass_q <= pass_q - 8'd1;
                rem_q  <= w_csize;
                addr_q <= w_cbase;
              end
            end else if (buf_space_ok_i[c]) begin
              st_q    <= S_REQ;
              req_q   <= 1'b1;
              xsize_q <= w_chunk;
            end
          end
          S_REQ: begin
            if (end_conv_i) begin
              st_q  <= S_IDLE;
              req_q <= 1'b0;
            end else begin
              st_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            // An end_conv seen mid-transfer is remembered so the read still completes.
            if (rd_if.rd_done[c]) begin
              req_q   <= 1'b0;
              addr_q  <= addr_q + ADDR_W'(xsize_q);
              rem_q   <= rem_q - xsize_q;
              abort_q <= 1'b0;
              st_q    <= (abort_q || end_conv_i) ? S_IDLE : S_CHECK;
            end else if (end_conv_i) begin
              abort_q <= 1'b1;
            end
          end
          S_DONE: begin
            if (end_conv_i) begin
              st_q  <= S_IDLE;
              clr_q <= 1'b0;
            end
          end
          default: begin
            st_q  <= S_IDLE;
            req_q <= 1'b0;
            clr_q <= 1'b0;
          end
        endcase
      end
    end

    assign w_idle[c]                 = (st_q == S_IDLE);
    assign w_req[c]                  = req_q;
    assign w_clr[c]                  = clr_q;
    assign w_off[c*ADDR_W +: ADDR_W]  = addr_q;
    assign w_size[c*ADDR_W +: ADDR_W] = ADDR_W'(xsize_q);
  end

  assign rd_if.rd_req       = w_req;
  assign rd_if.rd_offset    = w_off;
  assign rd_if.rd_xfer_size = w_size;
  assign xfer_clear_o       = w_clr;
  assign busy_o             = busy_q;
  assign g_stall_o          = w_stall;
  assign start_conv_o       = (pend_q | p_start_q) & ~w_stall;

endmodule

`default_nettype wire

// File: tb/tb_multi_ch_xfer_sched.sv
// ============================================================================
// tb_multi_ch_xfer_sched - directed scoreboard bench for multi_ch_xfer_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multi_ch_xfer_sched;

  localparam int NCH   = 2;
  localparam int AW    = 64;
  localparam int SW    = 32;
  localparam int CHUNK = 4096;

  typedef struct packed {
    logic [63:0] off;
    logic [63:0] sz;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            op_start = 1'b0;
  logic [NCH*AW-1:0] cfg_base = '0;
  logic [NCH*SW-1:0] cfg_size = '0;
  logic [NCH*8-1:0]  cfg_pass = '0;
  logic [NCH-1:0]  buf_space_ok = '1;
  logic [NCH-1:0]  buf_empty = '0;
  logic            end_conv = 1'b0;
  logic            g_stall, start_conv, busy;
  logic [NCH-1:0]  xfer_clear;

  logic [NCH-1:0]  auto_done = 2'b11;
  logic [NCH-1:0]  rd_done_auto = 2'b00;
  logic [NCH-1:0]  rd_done_man = 2'b00;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          req_cnt[NCH];
  int          sc_cnt = 0;
  int          rsp_cnt[NCH];
  logic [NCH-1:0] prev_req = '0;
  logic [63:0] hold_off[NCH];
  logic [63:0] hold_sz[NCH];

  multi_ch_xfer_sched_if #(.NUM_CH(NCH), .ADDR_W(AW)) rd_if ();

  assign rd_if.rd_done = rd_done_auto | rd_done_man;

  multi_ch_xfer_sched #(
    .NUM_CH(NCH), .ADDR_W(AW), .SIZE_W(SW), .CHUNK_BYTES(CHUNK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .op_start_i(op_start),
    .cfg_base_i(cfg_base),
    .cfg_size_i(cfg_size),
    .cfg_pass_i(cfg_pass),
    .rd_if(rd_if),
    .buf_space_ok_i(buf_space_ok),
    .buf_empty_i(buf_empty),
    .end_conv_i(end_conv),
    .g_stall_o(g_stall),
    .start_conv_o(start_conv),
    .xfer_clear_o(xfer_clear),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [63:0] off, input logic [63:0] sz);
    exp_t e;
    e.off = off;
    e.sz  = sz;
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic set_cfg(input int c, input logic [63:0] base, input logic [31:0] size,
                         input logic [7:0] pass);
    cfg_base[c*AW +: AW] = base;
    cfg_size[c*SW +: SW] = size;
    cfg_pass[c*8 +: 8]   = pass;
  endtask

  task automatic start_op();
    op_start = 1'b1;
    step();
    op_start = 1'b0;
  endtask

  task automatic end_op(input string tag);
    end_conv = 1'b1;
    step();
    end_conv = 1'b0;
    for (int i = 0; i < 50 && busy !== 1'b0; i++) step();
    chk(tag, busy, 1'b0);
  endtask

  // Slave model (3-cycle done after each request) plus request scoreboard.
  initial begin : mon
    exp_t        e;
    logic        got;
    logic [63:0] off, sz;
    for (int c = 0; c < NCH; c++) begin
      req_cnt[c] = 0;
      rsp_cnt[c] = 0;
    end
    forever begin
      @(negedge clk);
      if (start_conv === 1'b1) sc_cnt++;
      for (int c = 0; c < NCH; c++) begin
        off = rd_if.rd_offset[c*AW +: AW];
        sz  = rd_if.rd_xfer_size[c*AW +: AW];
        if (rd_if.rd_req[c] && !prev_req[c]) begin
          req_cnt[c]++;
          got = 1'b0;
          if (c == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          if (c == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          chk($sformatf("req_expected_ch%0d", c), got, 1'b1);
          if (got) begin
            chk($sformatf("req_offset_ch%0d", c), off, e.off);
            chk($sformatf("req_size_ch%0d", c), sz, e.sz);
          end
          hold_off[c] = off;
          hold_sz[c]  = sz;
        end else if (rd_if.rd_req[c] && prev_req[c]) begin
          chk($sformatf("offset_stable_ch%0d", c), off, hold_off[c]);
          chk($sformatf("size_stable_ch%0d", c), sz, hold_sz[c]);
        end
        prev_req[c] = rd_if.rd_req[c];
        if (auto_done[c] && rd_if.rd_req[c] && !rd_done_auto[c]) begin
          rsp_cnt[c]++;
          if (rsp_cnt[c] == 3) begin
            rd_done_auto[c] = 1'b1;
            rsp_cnt[c] = 0;
          end
        end else begin
          rsp_cnt[c] = 0;
          rd_done_auto[c] = 1'b0;
        end
      end
    end
  end

  initial begin : main
    logic [63:0] A, B;
    int          sc0, r0, r1;
    A = 64'h0000_00AB_0000_1000;
    B = 64'h0000_0000_2000_0000;

    // Reset state
    buf_empty = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_req", rd_if.rd_req, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_xfer_clear", xfer_clear, 2'b00);
    chk("rst_start_conv", start_conv, 1'b0);
    chk("rst_g_stall", g_stall, 1'b0);
    chk("rst_offset", rd_if.rd_offset[63:0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    buf_empty = 2'b00;
    step();

    // Multi-chunk split on ch0, single chunk on ch1
    set_cfg(0, A, 32'd10000, 8'd1);
    set_cfg(1, B, 32'd4096, 8'd1);
    push(0, A, 64'd4096);
    push(0, A + 64'd4096, 64'd4096);
    push(0, A + 64'd8192, 64'd1808);
    push(1, B, 64'd4096);
    sc0 = sc_cnt; r0 = req_cnt[0]; r1 = req_cnt[1];
    start_op();
    chk("t1_busy_rise", busy, 1'b1);
    for (int i = 0; i < 300 && xfer_clear !== 2'b11; i++) step();
    chk("t1_xfer_clear", xfer_clear, 2'b11);
    chk("t1_q0_drained", q0.size(), 0);
    chk("t1_q1_drained", q1.size(), 0);
    chk("t1_req_cnt0", req_cnt[0] - r0, 3);
    chk("t1_req_cnt1", req_cnt[1] - r1, 1);
    chk("t1_start_once", sc_cnt - sc0, 1);
    end_conv = 1'b1;
    step();
    end_conv = 1'b0;
    chk("t1_clear_drop", xfer_clear, 2'b00);
    chk("t1_busy_hold", busy, 1'b1);
    step();
    chk("t1_busy_fall", busy, 1'b0);

    // Zero-size ch0, 3-pass ch1, op_start while busy ignored
    set_cfg(0, A, 32'd0, 8'd1);
    set_cfg(1, B, 32'd128, 8'd3);
    push(1, B, 64'd128);
    push(1, B, 64'd128);
    push(1, B, 64'd128);
    r0 = req_cnt[0]; r1 = req_cnt[1];
    start_op();
    chk("t2_clr0_c0", xfer_clear[0], 1'b0);
    step();
    chk("t2_clr0_c1", xfer_clear[0], 1'b0);
    step();
    chk("t2_clr0_c2", xfer_clear[0], 1'b1);
    set_cfg(1, B + 64'h100, 32'd64, 8'd1);
    start_op();
    for (int i = 0; i < 200 && (req_cnt[1] - r1) < 3; i++) step();
    chk("t2_third_req", req_cnt[1] - r1, 3);
    chk("t2_clr1_before_done", xfer_clear[1], 1'b0);
    for (int i = 0; i < 50 && xfer_clear !== 2'b11; i++) step();
    chk("t2_xfer_clear", xfer_clear, 2'b11);
    chk("t2_no_req0", req_cnt[0] - r0, 0);
    chk("t2_q1_drained", q1.size(), 0);
    end_op("t2_end_busy");

    // Stalled start: buf_empty[0] high for 20 cycles, ch0 parked in WAIT
    auto_done[0] = 1'b0;
    set_cfg(0, A, 32'd10000, 8'd1);
    set_cfg(1, B, 32'd0, 8'd1);
    push(0, A, 64'd4096);
    buf_empty = 2'b01;
    sc0 = sc_cnt;
    start_op();
    for (int i = 0; i < 20; i++) begin
      chk("t3_stall", g_stall, 1'b1);
      chk("t3_no_start", start_conv, 1'b0);
      step();
    end
    buf_empty = 2'b00;
    #1;
    chk("t3_start_pulse", start_conv, 1'b1);
    chk("t3_stall_off", g_stall, 1'b0);
    step();
    chk("t3_start_gone", start_conv, 1'b0);
    chk("t3_start_once", sc_cnt - sc0, 1);

    // end_conv while ch0 is in WAIT
    chk("t4_req0_wait", rd_if.rd_req[0], 1'b1);
    end_conv = 1'b1;
    step();
    end_conv = 1'b0;
    chk("t4_req0_held", rd_if.rd_req[0], 1'b1);
    chk("t4_clear_drop", xfer_clear, 2'b00);
    repeat (3) step();
    chk("t4_req0_still", rd_if.rd_req[0], 1'b1);
    chk("t4_busy_still", busy, 1'b1);
    rd_done_man[0] = 1'b1;
    step();
    rd_done_man[0] = 1'b0;
    chk("t4_req0_drop", rd_if.rd_req[0], 1'b0);
    chk("t4_busy_hold", busy, 1'b1);
    step();
    chk("t4_busy_fall", busy, 1'b0);
    auto_done[0] = 1'b1;
    push(0, A, 64'd4096);
    push(0, A + 64'd4096, 64'd4096);
    push(0, A + 64'd8192, 64'd1808);
    start_op();
    for (int i = 0; i < 300 && xfer_clear !== 2'b11; i++) step();
    chk("t4_restart_clear", xfer_clear, 2'b11);
    chk("t4_q0_drained", q0.size(), 0);
    end_op("t4_end_busy");

    // Async reset mid-WAIT
    auto_done[0] = 1'b0;
    set_cfg(0, B, 32'd4096, 8'd1);
    push(0, B, 64'd4096);
    buf_empty = 2'b11;
    start_op();
    for (int i = 0; i < 20 && rd_if.rd_req[0] !== 1'b1; i++) step();
    chk("t6_req_up", rd_if.rd_req[0], 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", rd_if.rd_req, 2'b00);
    chk("t6_rst_off", rd_if.rd_offset[63:0], 64'd0);
    chk("t6_rst_size", rd_if.rd_xfer_size[63:0], 64'd0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_stall", g_stall, 1'b0);
    chk("t6_rst_start", start_conv, 1'b0);
    chk("t6_rst_clear", xfer_clear, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    buf_empty = 2'b00;
    auto_done[0] = 1'b1;
    r0 = req_cnt[0];
    repeat (10) step();
    chk("t6_no_req_after", req_cnt[0] - r0, 0);
    chk("t6_idle_busy", busy, 1'b0);
    push(0, B, 64'd4096);
    start_op();
    for (int i = 0; i < 100 && xfer_clear !== 2'b11; i++) step();
    chk("t6_new_op_clear", xfer_clear, 2'b11);
    chk("t6_q0_drained", q0.size(), 0);
    end_op("t6_end_busy");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/multi_ch_xfer_sched.md
Name: multi_ch_xfer_sched

Overview:
- Parametrised successor to the per-engine read-master control: one scheduler for NUM_CH input streams (IFM, WGT, bias, ...) instead of hard-wired IFM/WGT pairs.
- Per channel, it splits a configured byte region into bounded transfer chunks and drives the read-master req/done handshake with offset and transfer size.
- It supports multiple passes over a region (weight reuse), aggregates buffer stall into the engine-wide stall, and produces the single conv start pulse.

Parameters:
- NUM_CH, 2, number of read channels (1..8).
- ADDR_W, 64, address and offset width.
- SIZE_W, 32, byte-count width.
- CHUNK_BYTES, 4096, maximum bytes per request (power of two, ≥ 64).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op_start  in  1  one-cycle operation start pulse
- cfg_base  in  NUM_CH*ADDR_W  per-channel region base address
- cfg_size  in  NUM_CH*SIZE_W  per-channel region size in bytes
- cfg_pass  in  NUM_CH*8  per-channel pass count; 0 is treated as 1
- rd_req  out  NUM_CH  per-channel read request level
- rd_done  in  NUM_CH  per-channel one-cycle transfer-complete pulse
- rd_offset  out  NUM_CH*ADDR_W  per-channel request address
- rd_xfer_size  out  NUM_CH*ADDR_W  per-channel request bytes, zero-extended
- buf_space_ok  in  NUM_CH  buffer can accept CHUNK_BYTES
- buf_empty  in  NUM_CH  buffer has no word for the consumer
- end_conv  in  1  operation end / clear pulse
- g_stall  out  1  global stall
- start_conv  out  1  one-cycle compute start pulse
- xfer_clear  out  NUM_CH  channel has issued and completed all requests
- busy  out  1  operation in progress

Behaviour:
- Reset: every output is 0, all channel FSMs are IDLE, counters are 0, and config registers are 0.
- op_start latency:
  - Config is captured on the op_start cycle if busy=0; op_start while busy=1 is ignored.
  - The captured start becomes internal p_start one cycle later.
  - busy rises with p_start.
- Per-channel FSM:
  - IDLE: on p_start, load rem=size, addr=base, pass=max(cfg_pass,1); go to CHECK.
  - CHECK: if rem=0 and pass≤1, go to DONE. If rem=0 and pass>1, then pass−1, reload rem/addr, stay in CHECK. Else if buf_space_ok, go to REQ.
  - REQ: rd_req=1; rd_offset=addr; rd_xfer_size=min(rem, CHUNK_BYTES). Go to WAIT the next cycle.
  - WAIT: rd_req stays 1 and offset/size stay stable until rd_done. On rd_done: rd_req=0 the next cycle, addr+=size (modulo 2^ADDR_W), rem−=size; go to CHECK.
  - DONE: xfer_clear=1; hold until end_conv.
- Size rule: a non-multiple-of-CHUNK remainder is issued as-is as the last chunk. cfg_size=0 means the channel goes straight to DONE and never asserts rd_req.
- rd_done outside WAIT is ignored.
- g_stall = OR over i of (buf_empty[i] & ~xfer_clear[i] & busy).
- start_conv:
  - A pending flag is set by p_start.
  - start_conv=1 for exactly one cycle on the first cycle with pending & ~g_stall; pending then clears.
  - If p_start and ~g_stall coincide, start_conv fires that same cycle.
- end_conv:
  - Channels in IDLE/CHECK/REQ/DONE go to IDLE the next cycle, and xfer_clear clears.
  - A channel in WAIT keeps rd_req high until its rd_done, then goes to IDLE (no orphan transfer).
  - busy falls when all channels are IDLE.
  - pending start clears.
- Simultaneous rd_done and end_conv in WAIT: the completion is accounted, then the channel goes to IDLE.
- Channels are fully independent; no arbitration is needed because each channel has its own master.

Test Plan:
- NUM_CH=2, size0=10000, size1=4096, pass=1, buf_space_ok=1, rd_done 3 cycles after each req.
  - ch0 offsets base, +4096, +8192 with sizes 4096, 4096, 1808.
  - ch1 has one 4096 request.
  - xfer_clear=2'b11 after the last done.
- cfg_pass1=3, size1=128.
  - ch1 issues three requests, all at offset base1, size 128.
  - xfer_clear[1] sets only after the third done.
- buf_empty[0]=1 through cycle 20 after op_start.
  - g_stall=1 and start_conv stays 0 throughout.
  - buf_empty falls at cycle 21 → start_conv pulses exactly once at cycle 21.
- end_conv while ch0 is in WAIT.
  - rd_req0 holds until rd_done0, then drops; busy falls the cycle after.
  - A second op_start then restarts from base0.
- cfg_size0=0: rd_req0 never asserts; xfer_clear[0]=1 two cycles after op_start.
  - op_start pulsed while busy is ignored (offsets unchanged).
- Assert rst_n low mid-WAIT: all outputs are 0 immediately (async); after release, no request issues until a new op_start.
